// File: rtl/ssd_digit_driver.sv
// Two-digit BCD up/down counter with a time-multiplexed digit scanner feeding a 7-segment decoder.
// Optional build macro SSD_BLANK_LEADING_ZERO_EN blanks the tens digit while it holds a leading zero.
//
// state    | meaning
// DIG_ONES | ones digit is being driven onto digit_x / digit_sel
// DIG_TENS | tens digit is being driven (or blanked when leading-zero blanking applies)
module ssd_digit_driver #(
  parameter int PRESCALE = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic [3:0] digit_x,
  output logic [1:0] digit_sel,
  output logic       carry
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic {DIG_ONES = 1'b0, DIG_TENS = 1'b1} dig_t;

  logic [PW-1:0] presc_q;
  logic [SW-1:0] scan_q;
  logic          tick;
  logic          scan_wrap;
  logic [7:0]    count_q, count_nxt;
  logic          carry_nxt;
  dig_t          state_q, state_nxt;
  logic [3:0]    x_nxt;
  logic [1:0]    sel_nxt;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t, o;
    t = v[7:4];
    o = v[3:0];
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] t, o;
    t = v[7:4];
    o = v[3:0];
    if (o == 4'd0) begin
      o = 4'd9;
      t = (t == 4'd0) ? 4'd9 : t - 4'd1;
    end else begin
      o = o - 4'd1;
    end
    return {t, o};
  endfunction

  // Out-of-range nibbles load as zero so the counter never leaves 00..99.
  function automatic logic [7:0] bcd_clean(input logic [7:0] v);
    logic [3:0] t, o;
    t = (v[7:4] > 4'd9) ? 4'd0 : v[7:4];
    o = (v[3:0] > 4'd9) ? 4'd0 : v[3:0];
    return {t, o};
  endfunction

  assign tick      = (presc_q == PRESC_MAX);
  assign scan_wrap = (scan_q == SCAN_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (clear || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  always_comb begin
    count_nxt = count_q;
    carry_nxt = 1'b0;
    if (clear) begin
      count_nxt = 8'h00;
    end else if (load) begin
      count_nxt = bcd_clean(load_val);
    end else if (tick && en) begin
      if (up) begin
        count_nxt = bcd_inc(count_q);
        carry_nxt = (count_q == 8'h99);
      end else begin
        count_nxt = bcd_dec(count_q);
        carry_nxt = (count_q == 8'h00);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'h00;
      carry   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      carry   <= carry_nxt;
    end
  end

  assign count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
    end else if (scan_wrap) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIG_ONES;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Select and nibble are computed from the same next state so they never disagree.
  always_comb begin
    state_nxt = state_q;
    x_nxt     = count_q[3:0];
    sel_nxt   = 2'b01;
    if (scan_wrap) begin
      state_nxt = (state_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end
    case (state_nxt)
      DIG_ONES: begin
        x_nxt   = count_q[3:0];
        sel_nxt = 2'b01;
      end
      DIG_TENS: begin
        x_nxt   = count_q[7:4];
`ifdef SSD_BLANK_LEADING_ZERO_EN
        sel_nxt = (count_q[7:4] == 4'h0) ? 2'b00 : 2'b10;
`else
        sel_nxt = 2'b10;
`endif
      end
      default: begin
        x_nxt   = count_q[3:0];
        sel_nxt = 2'b01;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_x   <= 4'h0;
      digit_sel <= 2'b01;
    end else begin
      digit_x   <= x_nxt;
      digit_sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_digit_driver.sv
// Directed bench for ssd_digit_driver with PRESCALE=4, SCAN_DIV=3: count vector table plus scan/blank/reset sequences.
module tb_ssd_digit_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count;
  logic [3:0] digit_x;
  logic [1:0] digit_sel;
  logic       carry;

  int nvec = 0;
  int nmis = 0;
  int carry_pulses = 0;

  ssd_digit_driver #(.PRESCALE(4), .SCAN_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count), .digit_x(digit_x), .digit_sel(digit_sel), .carry(carry)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && carry) carry_pulses++;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       up;
    int         cyc;
    logic [7:0] exp_cnt;
    logic       exp_cy;
  } vec_t;

  vec_t vecs[26];

`ifdef SSD_BLANK_LEADING_ZERO_EN
  localparam logic [1:0] TENS_ZERO_SEL = 2'b00;
`else
  localparam logic [1:0] TENS_ZERO_SEL = 2'b10;
`endif

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] prev_sel, exp_sel;
    bit         seen;

    // Prescaler restarts at 0 on reset release, so ticks fall on edges 4, 8, 12, ... until a clear.
    vecs[0]  = '{0, 1, 8'h98, 1, 1, 1, 8'h98, 0};
    vecs[1]  = '{0, 0, 8'h00, 1, 1, 3, 8'h99, 0};
    vecs[2]  = '{0, 0, 8'h00, 1, 1, 3, 8'h99, 0};
    vecs[3]  = '{0, 0, 8'h00, 1, 1, 1, 8'h00, 1};
    vecs[4]  = '{0, 0, 8'h00, 1, 1, 1, 8'h00, 0};
    vecs[5]  = '{0, 1, 8'hA5, 1, 0, 1, 8'h05, 0};
    vecs[6]  = '{0, 0, 8'h00, 1, 0, 2, 8'h04, 0};
    vecs[7]  = '{0, 0, 8'h00, 1, 0, 4, 8'h03, 0};
    vecs[8]  = '{0, 0, 8'h00, 1, 0, 4, 8'h02, 0};
    vecs[9]  = '{0, 0, 8'h00, 1, 0, 4, 8'h01, 0};
    vecs[10] = '{0, 0, 8'h00, 1, 0, 4, 8'h00, 0};
    vecs[11] = '{0, 0, 8'h00, 1, 0, 3, 8'h00, 0};
    vecs[12] = '{0, 0, 8'h00, 1, 0, 1, 8'h99, 1};
    vecs[13] = '{0, 0, 8'h00, 1, 0, 1, 8'h99, 0};
    vecs[14] = '{0, 1, 8'h3C, 0, 0, 1, 8'h30, 0};
    vecs[15] = '{0, 0, 8'h00, 1, 1, 1, 8'h30, 0};
    vecs[16] = '{1, 1, 8'h42, 1, 1, 1, 8'h00, 0};
    vecs[17] = '{0, 0, 8'h00, 1, 1, 4, 8'h01, 0};
    vecs[18] = '{0, 0, 8'h00, 1, 1, 3, 8'h01, 0};
    vecs[19] = '{0, 1, 8'h42, 1, 1, 1, 8'h42, 0};
    vecs[20] = '{0, 0, 8'h00, 1, 1, 4, 8'h43, 0};
    vecs[21] = '{1, 0, 8'h00, 1, 1, 2, 8'h00, 0};
    vecs[22] = '{0, 0, 8'h00, 1, 1, 3, 8'h00, 0};
    vecs[23] = '{0, 0, 8'h00, 1, 1, 1, 8'h01, 0};
    vecs[24] = '{0, 0, 8'h00, 0, 1, 4, 8'h01, 0};
    vecs[25] = '{0, 0, 8'h00, 1, 0, 4, 8'h00, 0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_count", count, 8'h00);
    chk("reset_sel", {6'h0, digit_sel}, 8'h01);
    chk("reset_x", {4'h0, digit_x}, 8'h00);
    chk("reset_carry", {7'h0, carry}, 8'h00);

    for (int i = 0; i < 26; i++) begin
      clear    = vecs[i].clr;
      load     = vecs[i].ld;
      load_val = vecs[i].lv;
      en       = vecs[i].en;
      up       = vecs[i].up;
      repeat (vecs[i].cyc) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_carry", i), {7'h0, carry}, {7'h0, vecs[i].exp_cy});
    end
    clear = 1'b0;
    load  = 1'b0;
    chk("carry_pulse_total", 8'(carry_pulses), 8'd2);

    // Scan: load 37 with counting off, then follow four full digit slots.
    en = 1'b0;
    load = 1'b1;
    load_val = 8'h37;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    prev_sel = digit_sel;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (digit_sel != prev_sel) seen = 1'b1;
    end
    chk("scan_toggle_seen", {7'h0, seen}, 8'h01);
    exp_sel = (digit_sel == 2'b10) ? 2'b10 : 2'b01;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("scan_s%0d_c%0d_sel", s, c), {6'h0, digit_sel}, {6'h0, exp_sel});
        chk($sformatf("scan_s%0d_c%0d_x", s, c), {4'h0, digit_x}, (exp_sel == 2'b01) ? 8'h07 : 8'h03);
        @(negedge clk);
      end
      exp_sel = (exp_sel == 2'b01) ? 2'b10 : 2'b01;
    end

    // Leading zero: count 07, observe the tens slot.
    load = 1'b1;
    load_val = 8'h07;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (digit_sel != 2'b01) seen = 1'b1;
      else @(negedge clk);
    end
    chk("blank_slot_seen", {7'h0, seen}, 8'h01);
    chk("blank_tens_sel", {6'h0, digit_sel}, {6'h0, TENS_ZERO_SEL});
    chk("blank_tens_x", {4'h0, digit_x}, 8'h00);
    chk("count_07", count, 8'h07);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", count, 8'h00);
    chk("async_sel", {6'h0, digit_sel}, 8'h01);
    chk("async_x", {4'h0, digit_x}, 8'h00);
    chk("async_carry", {7'h0, carry}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_count", count, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
